// File: rtl/pipe_pkg.sv
// Shared MEM->WB types: default widths, the bundle struct and its reset value.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int RN_W   = 5;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [DATA_W-1:0] mo;
    logic [DATA_W-1:0] alu;
    logic [RN_W-1:0]   rn;
  } mw_bundle_t;

  localparam mw_bundle_t MW_BUNDLE_RST = '0;
endpackage

// File: rtl/mw_skid_buf.sv
// Generic 2-entry skid buffer: MAIN drives the output, SKID absorbs one bundle under
// backpressure so in_ready comes straight from a flop.
module mw_skid_buf #(
  parameter type T = pipe_pkg::mw_bundle_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  T           in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output T           out_data,
  output logic [1:0] count
);
  T     main_q, main_d, skid_q, skid_d;
  logic mv_q, mv_d, sv_q, sv_d;
  logic accept, retire;

  assign in_ready  = ~sv_q;
  assign accept    = in_valid & ~sv_q;
  assign retire    = mv_q & out_ready;
  assign out_valid = mv_q;
  assign out_data  = main_q;
  assign count     = {1'b0, mv_q} + {1'b0, sv_q};

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    mv_d   = mv_q;
    sv_d   = sv_q;
    if (flush) begin
      // payload left stale on purpose; valids alone gate visibility
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (sv_q) begin
      if (retire) begin
        main_d = skid_q;
        sv_d   = 1'b0;
      end
    end else if (mv_q) begin
      if (accept && retire) begin
        main_d = in_data;
      end else if (accept) begin
        skid_d = in_data;
        sv_d   = 1'b1;
      end else if (retire) begin
        mv_d = 1'b0;
      end
    end else if (accept) begin
      main_d = in_data;
      mv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      mv_q   <= mv_d;
      sv_q   <= sv_d;
    end
  end
endmodule

// File: rtl/pipe_mw_stage.sv
// Elastic MEM->WB stage with flush, occupancy and r0 write squash.
// Optional macro MW_BYPASS_EN adds wdata/fwd_rn/fwd_hit forwarding ports.
module pipe_mw_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RN_W   = pipe_pkg::RN_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [DATA_W-1:0] mmo,
  input  logic [DATA_W-1:0] malu,
  input  logic [RN_W-1:0]   mrn,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [RN_W-1:0]   wrn,
  output logic [1:0]        w_count
`ifdef MW_BYPASS_EN
  ,
  input  logic [RN_W-1:0]   fwd_rn,
  output logic [DATA_W-1:0] wdata,
  output logic              fwd_hit
`endif
);
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [DATA_W-1:0] mo;
    logic [DATA_W-1:0] alu;
    logic [RN_W-1:0]   rn;
  } bundle_t;

  bundle_t in_b, main_b;

  // r0 is hardwired, so a write to it is dropped at capture
  always_comb begin
    in_b       = '0;
    in_b.wreg  = mwreg & (mrn != '0);
    in_b.m2reg = mm2reg;
    in_b.mo    = mmo;
    in_b.alu   = malu;
    in_b.rn    = mrn;
  end

  mw_skid_buf #(.T(bundle_t)) u_skid (
    .clk      (clk),
    .rst      (clr),
    .flush    (flush),
    .in_valid (m_valid),
    .in_ready (m_ready),
    .in_data  (in_b),
    .out_valid(w_valid),
    .out_ready(w_ready),
    .out_data (main_b),
    .count    (w_count)
  );

  assign wwreg  = main_b.wreg & w_valid;
  assign wm2reg = main_b.m2reg;
  assign wmo    = main_b.mo;
  assign walu   = main_b.alu;
  assign wrn    = main_b.rn;

`ifdef MW_BYPASS_EN
  assign wdata   = main_b.m2reg ? main_b.mo : main_b.alu;
  assign fwd_hit = wwreg & (main_b.rn == fwd_rn);
`endif
endmodule

// File: tb/tb_pipe_mw_stage.sv
// Self-checking bench for pipe_mw_stage: directed cases plus random traffic vs a FIFO model.
module tb_pipe_mw_stage;
  logic        clk = 1'b0;
  logic        clr, flush, m_valid, mwreg, mm2reg, w_ready;
  logic [31:0] mmo, malu;
  logic [4:0]  mrn;
  logic        m_ready, w_valid, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
  logic [1:0]  w_count;
`ifdef MW_BYPASS_EN
  logic [4:0]  fwd_rn;
  logic [31:0] wdata;
  logic        fwd_hit;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wreg;
    bit          m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } mb_t;
  mb_t q[$];

  pipe_mw_stage dut (
    .clk(clk), .clr(clr), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .mwreg(mwreg), .mm2reg(mm2reg), .mmo(mmo), .malu(malu), .mrn(mrn),
    .w_valid(w_valid), .w_ready(w_ready), .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn), .w_count(w_count)
`ifdef MW_BYPASS_EN
    , .fwd_rn(fwd_rn), .wdata(wdata), .fwd_hit(fwd_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a 2-deep FIFO; stage is ready whenever fewer than 2 are held.
  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, ".w_valid"}, 64'(w_valid), 64'(n > 0));
    chk({tag, ".m_ready"}, 64'(m_ready), 64'(n < 2));
    chk({tag, ".w_count"}, 64'(w_count), 64'(n));
    if (n > 0) begin
      chk({tag, ".walu"},   64'(walu),   64'(q[0].alu));
      chk({tag, ".wmo"},    64'(wmo),    64'(q[0].mo));
      chk({tag, ".wm2reg"}, 64'(wm2reg), 64'(q[0].m2reg));
      chk({tag, ".wrn"},    64'(wrn),    64'(q[0].rn));
      chk({tag, ".wwreg"},  64'(wwreg),  64'(q[0].wreg));
`ifdef MW_BYPASS_EN
      chk({tag, ".wdata"},  64'(wdata),  64'(q[0].m2reg ? q[0].mo : q[0].alu));
      chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(q[0].wreg && q[0].rn == fwd_rn));
`endif
    end else begin
      chk({tag, ".wwreg0"}, 64'(wwreg), 64'(0));
`ifdef MW_BYPASS_EN
      chk({tag, ".fwd_hit0"}, 64'(fwd_hit), 64'(0));
`endif
    end
  endtask

  task automatic tick(input string tag);
    bit acc, ret;
    mb_t b;
    acc = m_valid && (q.size() < 2);
    ret = (q.size() > 0) && w_ready;
    b.wreg = mwreg && (mrn != 0);
    b.m2reg = mm2reg; b.mo = mmo; b.alu = malu; b.rn = mrn;
    if (flush) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit wr, input bit m2, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] rn);
    m_valid = v; mwreg = wr; mm2reg = m2; mmo = mo; malu = alu; mrn = rn;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; w_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef MW_BYPASS_EN
    fwd_rn = '0;
`endif
    #12 clr = 1'b0;
    #2 check_all("reset");

    // streaming, full throughput
    w_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 0, 32'h0, 32'(k), 5'd1);
      tick("stream");
      chk("stream.walu_k", 64'(walu), 64'(k));
      chk("stream.cnt1", 64'(w_count), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick("stream_drain");

    // backpressure: A, B fill both entries, C held off
    w_ready = 1'b0;
    drive(1, 1, 0, 32'h0, 32'hA, 5'd2); tick("bp_a");
    drive(1, 1, 0, 32'h0, 32'hB, 5'd2); tick("bp_b");
    chk("bp.full_cnt", 64'(w_count), 64'd2);
    chk("bp.ready0", 64'(m_ready), 64'd0);
    drive(1, 1, 0, 32'h0, 32'hC, 5'd2); tick("bp_c_held");
    chk("bp.hold_a", 64'(walu), 64'hA);
    w_ready = 1'b1;
    tick("bp_r1"); chk("bp.out_b", 64'(walu), 64'hB);
    tick("bp_r2"); chk("bp.out_c", 64'(walu), 64'hC);
    drive(0, 0, 0, 0, 0, 0);
    tick("bp_r3"); chk("bp.empty", 64'(w_valid), 64'd0);

    // flush with a simultaneous accept
    w_ready = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h11, 5'd4); tick("fl_a");
    drive(1, 1, 0, 32'h0, 32'h22, 5'd4); tick("fl_b");
    drive(1, 1, 0, 32'h0, 32'h33, 5'd4); flush = 1'b1; tick("fl_go");
    chk("flush.valid", 64'(w_valid), 64'd0);
    chk("flush.cnt", 64'(w_count), 64'd0);
    flush = 1'b0;
    drive(1, 1, 1, 32'h44, 32'h45, 5'd6); tick("fl_new");
    chk("flush.new", 64'(walu), 64'h45);
    w_ready = 1'b1; drive(0, 0, 0, 0, 0, 0); tick("fl_drain");

    // r0 squash
    drive(1, 1, 0, 32'h0, 32'h55, 5'd0); tick("sq0");
    chk("squash.walu", 64'(walu), 64'h55);
    chk("squash.wwreg", 64'(wwreg), 64'd0);
    drive(1, 1, 0, 32'h0, 32'h56, 5'd3); tick("sq3");
    chk("squash.r3", 64'(wwreg), 64'd1);
    drive(0, 0, 0, 0, 0, 0); tick("sq_drain");

`ifdef MW_BYPASS_EN
    fwd_rn = 5'd7;
    drive(1, 1, 1, 32'h1234, 32'h9, 5'd7); tick("byp");
    chk("byp.wdata", 64'(wdata), 64'h1234);
    chk("byp.hit", 64'(fwd_hit), 64'd1);
    fwd_rn = 5'd6; #1;
    chk("byp.miss", 64'(fwd_hit), 64'd0);
    drive(0, 0, 0, 0, 0, 0); tick("byp_drain");
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, 5'($urandom_range(0, 3)));
      w_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
`ifdef MW_BYPASS_EN
      fwd_rn = 5'($urandom_range(0, 3));
`endif
      tick("rand");
    end
    flush = 1'b0;

    // async reset mid-stream, between clock edges
    w_ready = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h77, 5'd5); tick("rst_a");
    drive(1, 1, 0, 32'h0, 32'h78, 5'd5); tick("rst_b");
    clr = 1'b1; #2;
    q.delete();
    chk("rst.walu", 64'(walu), 64'd0);
    check_all("rst_mid");
    clr = 1'b0; drive(0, 0, 0, 0, 0, 0); #1;
    tick("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
